laser_tx_multichannel: RTL and testbench

- Parametrised successor to the fixed two-laser transmitter. It drives NUM_CH differential laser lanes from a single system clock.
- Replaces the external divided-clock scheme with an internal programmable baud-tick generator shared by all lanes, so lanes stay bit-aligned.
- Adds per-lane valid/ready handshake, framing (start, data, optional even parity, stop), a per-lane done pulse, and clean abort on enable drop.
- Sits between the packet/byte source and the GPIO laser driver pins.

---
 rtl/laser_tx_multichannel_if.sv | 12 +
 rtl/laser_tx_multichannel.sv | 123 ++++++++++++
 tb/tb_laser_tx_multichannel.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/laser_tx_multichannel_if.sv
// Per-lane byte handshake between the packet source (master) and the laser transmitter (slave).
interface laser_tx_multichannel_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 8
);
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic [NUM_CH-1:0]        data_valid;
    logic [NUM_CH-1:0]        data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/laser_tx_multichannel.sv
// Multi-lane framed laser transmitter: shared baud tick, per-lane start/data/parity/stop framing.
module laser_tx_multichannel #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DIV_W-1:0]      divider,
    input  logic                  parity_en,
    laser_tx_multichannel_if.slave bus,
    output logic [2*NUM_CH-1:0]   laser_out,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     done
);

    localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t            state_q   [NUM_CH];
    logic [IdxW-1:0]   idx_q     [NUM_CH];
    logic [DATA_W-1:0] payload_q [NUM_CH];
    logic [NUM_CH-1:0] par_q;
    logic [DIV_W-1:0]  cnt_q;

    logic              active;
    logic              tick;
    logic [NUM_CH-1:0] line;
    logic [NUM_CH-1:0] ready;

    assign active = en && !reset;
    // >= rather than == so a divider lowered mid-frame cannot strand the counter above it.
    assign tick   = (cnt_q >= divider);

    always_ff @(posedge clock) begin
        if (!active) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!active) begin
                state_q[i] <= StIdle;
                idx_q[i]   <= '0;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        if (bus.data_valid[i]) begin
                            payload_q[i] <= bus.data_in[i*DATA_W +: DATA_W];
                            par_q[i]     <= parity_en;
                            state_q[i]   <= StWait;
                        end
                    end
                    StWait: begin
                        if (tick) state_q[i] <= StStart;
                    end
                    StStart: begin
                        if (tick) begin
                            state_q[i] <= StData;
                            idx_q[i]   <= '0;
                        end
                    end
                    StData: begin
                        if (tick) begin
                            if (idx_q[i] == LastIdx) begin
                                state_q[i] <= par_q[i] ? StParity : StStop;
                            end else begin
                                idx_q[i] <= idx_q[i] + 1'b1;
                            end
                        end
                    end
                    StParity: begin
                        if (tick) state_q[i] <= StStop;
                    end
                    StStop: begin
                        if (tick) state_q[i] <= StIdle;
                    end
                    default: state_q[i] <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        line      = '0;
        ready     = '0;
        busy      = '0;
        done      = '0;
        laser_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            unique case (state_q[i])
                StStart:  line[i] = 1'b1;
                StData:   line[i] = payload_q[i][idx_q[i]];
                StParity: line[i] = ^payload_q[i];
                default:  line[i] = 1'b0;
            endcase
            ready[i]         = active && (state_q[i] == StIdle);
            busy[i]          = active && (state_q[i] != StIdle);
            done[i]          = active && tick && (state_q[i] == StStop);
            // Both pins dark while disabled; otherwise a complementary pair.
            laser_out[2*i]   = active && line[i];
            laser_out[2*i+1] = active && !line[i];
        end
    end

    assign bus.data_ready = ready;

endmodule

// File: tb/tb_laser_tx_multichannel.sv
// Scoreboard bench: accepted frames queue an expected waveform; a monitor compares each finished frame.
module tb_laser_tx_multichannel;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
    localparam int DW     = NUM_CH * DATA_W;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                en = 1'b0;
    logic                parity_en = 1'b0;
    logic [DIV_W-1:0]    divider = 16'd3;
    logic [2*NUM_CH-1:0] laser_out;
    logic [NUM_CH-1:0]   busy;
    logic [NUM_CH-1:0]   done;

    laser_tx_multichannel_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    laser_tx_multichannel #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .divider   (divider),
        .parity_en (parity_en),
        .bus       (bus),
        .laser_out (laser_out),
        .busy      (busy),
        .done      (done)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                par;
        int                div;
        int                acc;
    } frame_t;

    frame_t exp_q [NUM_CH][$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int done_total = 0;

    bit rec_on    [NUM_CH];
    int rec_len   [NUM_CH];
    bit rec       [NUM_CH][256];
    bit comp_bad  [NUM_CH];
    int start_cyc [NUM_CH];
    int done_cyc  [NUM_CH];
    bit chk_rdy   [NUM_CH];
    bit ln;
    frame_t pf;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    endtask

    // Reference waveform: each symbol held divider+1 cycles; start=1, data LSB first, even parity, stop=0.
    task automatic compare_frame(input int i, input frame_t f);
        int bp, nbits, errs, b, wl;
        bit e;
        bp    = f.div + 1;
        nbits = DATA_W + 2 + (f.par ? 1 : 0);
        errs  = 0;
        chk($sformatf("frame_len lane%0d data=%02h", i, f.data), rec_len[i], bp * nbits);
        for (int k = 0; k < rec_len[i] && k < 256; k++) begin
            b = k / bp;
            if (b == 0) e = 1'b1;
            else if (b <= DATA_W) e = f.data[b-1];
            else if (f.par && b == DATA_W + 1) e = ($countones(f.data) % 2) == 1;
            else e = 1'b0;
            if (rec[i][k] != e) errs++;
        end
        chk($sformatf("frame_bits lane%0d data=%02h", i, f.data), errs, 0);
        chk($sformatf("complement lane%0d", i), comp_bad[i], 0);
        wl = start_cyc[i] - f.acc;
        chk($sformatf("wait_len lane%0d wl=%0d", i, wl), (wl >= 1 && wl <= f.div + 1), 1);
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (chk_rdy[i]) begin
                chk_rdy[i] = 1'b0;
                if (en && !reset) chk($sformatf("ready_after_done lane%0d", i), bus.data_ready[i], 1);
            end
            if (done[i]) done_total++;
            if (reset || !en) begin
                rec_on[i] = 1'b0;
            end else begin
                ln = laser_out[2*i];
                if (!rec_on[i] && busy[i] && ln) begin
                    rec_on[i]    = 1'b1;
                    rec_len[i]   = 0;
                    comp_bad[i]  = 1'b0;
                    start_cyc[i] = cyc;
                end
                if (rec_on[i]) begin
                    if (rec_len[i] < 256) rec[i][rec_len[i]] = ln;
                    rec_len[i]++;
                    if (laser_out[2*i+1] == ln) comp_bad[i] = 1'b1;
                end
                if (done[i]) begin
                    if (!rec_on[i] || exp_q[i].size() == 0) begin
                        chk($sformatf("unexpected_done lane%0d", i), 1, 0);
                    end else begin
                        pf = exp_q[i].pop_front();
                        compare_frame(i, pf);
                    end
                    rec_on[i]   = 1'b0;
                    done_cyc[i] = cyc;
                    chk_rdy[i]  = 1'b1;
                end
            end
        end
    end

    task automatic push_frames(input logic [NUM_CH-1:0] mask, input logic [DW-1:0] d, input bit par);
        frame_t f;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) begin
                f.data = d[i*DATA_W +: DATA_W];
                f.par  = par;
                f.div  = int'(divider);
                f.acc  = cyc + 1;
                exp_q[i].push_back(f);
            end
        end
    endtask

    task automatic send(input logic [NUM_CH-1:0] mask, input logic [DW-1:0] d, input bit par);
        bit ok;
        ok = 1'b0;
        @(posedge clock); #1;
        bus.data_in    = d;
        bus.data_valid = mask;
        parity_en      = par;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            if ((bus.data_ready & mask) == mask) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        else push_frames(mask, d, par);
        @(posedge clock); #1;
        bus.data_valid = '0;
        bus.data_in    = DW'($urandom);
        parity_en      = 1'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000 && !ok; n++) begin
            @(negedge clock);
            if (busy == '0 && exp_q[0].size() == 0 && exp_q[1].size() == 0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(negedge clock);
    endtask

    task automatic wait_rec(input int lane, input int len);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clock);
            if (rec_on[lane] && rec_len[lane] >= len) ok = 1'b1;
        end
        if (!ok) chk("rec_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        bit ok;
        bus.data_in    = '0;
        bus.data_valid = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_laser", laser_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", bus.data_ready, 0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("disabled_laser", laser_out, 0);
        chk("disabled_ready", bus.data_ready, 0);
        @(posedge clock); #1 en = 1'b1;
        @(negedge clock);
        chk("idle_laser", laser_out, 4'b1010);
        chk("idle_ready", bus.data_ready, 2'b11);
        chk("idle_busy", busy, 0);

        divider = 16'd3;
        send(2'b01, 16'h00F1, 1'b0);
        wait_idle();

        send(2'b11, 16'hF0F1, 1'b0);
        wait_idle();
        chk("start_aligned", start_cyc[0] - start_cyc[1], 0);
        chk("done_aligned", done_cyc[0] - done_cyc[1], 0);

        divider = 16'd1;
        send(2'b01, 16'h0007, 1'b1);
        wait_idle();
        send(2'b10, 16'h0300, 1'b1);
        wait_idle();

        divider = 16'd0;
        send(2'b01, 16'h00A5, 1'b0);
        wait_idle();

        // Valid held high across two frames; the second accept follows done by one cycle.
        divider = 16'd2;
        @(posedge clock); #1;
        bus.data_in    = 16'h003C;
        bus.data_valid = 2'b01;
        parity_en      = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            if (bus.data_ready[0]) ok = 1'b1;
        end
        push_frames(2'b01, 16'h003C, 1'b1);
        @(posedge clock); #1 bus.data_in = 16'h00C3;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            if (bus.data_ready[0]) ok = 1'b1;
        end
        chk("b2b_accept_seen", ok, 1);
        chk("b2b_gap", cyc - done_cyc[0], 1);
        push_frames(2'b01, 16'h00C3, 1'b1);
        @(posedge clock); #1 bus.data_valid = '0;
        wait_idle();

        // Abort by dropping enable during the fourth data bit.
        divider = 16'd3;
        send(2'b01, 16'h005A, 1'b0);
        wait_rec(0, 18);
        d0 = done_total;
        @(posedge clock); #1 en = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("abort_laser", laser_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", bus.data_ready, 0);
        exp_q[0].delete();
        repeat (5) @(negedge clock);
        chk("abort_no_done", done_total - d0, 0);
        @(posedge clock); #1 en = 1'b1;
        @(negedge clock);
        chk("reenable_ready", bus.data_ready, 2'b11);
        send(2'b01, 16'h0081, 1'b0);
        wait_idle();

        // One-cycle reset mid-frame with enable held.
        send(2'b10, 16'h9600, 1'b1);
        wait_rec(1, 10);
        d0 = done_total;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_laser", laser_out, 4'b1010);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", bus.data_ready, 2'b11);
        chk("rst_mid_cnt", dut.cnt_q, 0);
        exp_q[1].delete();
        repeat (4) @(negedge clock);
        chk("rst_mid_no_done", done_total - d0, 0);
        send(2'b10, 16'h6900, 1'b1);
        wait_idle();

        for (int it = 0; it < 15; it++) begin
            divider = 16'($urandom_range(0, 4));
            send(2'($urandom_range(1, 3)), DW'($urandom), 1'($urandom));
            wait_idle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
